// File: rtl/apb_pkg.sv
// Shared defaults and state encoding for the arbitrated APB master.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_arb_master_if.sv
// Requester command/response bundle plus the APB master-side bus.
interface apb_arb_master_if #(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0]            req_write;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]      rsp_rdata;
  logic                       rsp_err;
  logic                       PSELx;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [ADDR_WIDTH-1:0]      PADDR;
  logic [DATA_WIDTH-1:0]      PWDATA;
  logic [DATA_WIDTH-1:0]      PRDATA;
  logic                       PREADY;
  logic                       PSLVERR;
  logic                       timeout_o;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA, timeout_o
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA, timeout_o
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: combinational winner search from the pointer,
// pointer advances to winner+1 on each accept.
module apb_rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   winner,
  output logic            any
);

  logic [IW-1:0] ptr;
  logic [IW:0]   idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (!any && req[idx[IW-1:0]]) begin
        any                = 1'b1;
        winner             = idx[IW-1:0];
        grant[idx[IW-1:0]] = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by NREQ requesters through a round-robin arbiter,
// with per-transfer wait-state timeout.
//
// state  | meaning
// IDLE   | bus idle, arbiter may accept a command
// SETUP  | PSELx=1 PENABLE=0, one cycle
// ACCESS | PSELx=1 PENABLE=1, wait for PREADY or timeout
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int NREQ       = 2,
  parameter int TIMEOUT    = APB_TIMEOUT
) (
  input logic              PCLK,
  input logic              PRESETn,
  apb_arb_master_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  apb_state_e            state;
  logic [IW-1:0]         winner;
  logic [IW-1:0]         owner;
  logic [NREQ-1:0]       grant;
  logic                  any;
  logic                  ready_en;
  logic                  accept;
  logic [CW-1:0]         wait_cnt;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  apb_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .req     (bus.req_valid),
    .accept  (accept),
    .grant   (grant),
    .winner  (winner),
    .any     (any)
  );

  // A new command can be taken when idle or on the completing ACCESS cycle.
  assign ready_en      = PRESETn && ((state == IDLE) || ((state == ACCESS) && bus.PREADY));
  assign bus.req_ready = ready_en ? grant : '0;
  assign accept        = ready_en && any;

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IW'(i)) begin
        sel_write = bus.req_write[i];
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      owner         <= '0;
      wait_cnt      <= '0;
      bus.PSELx     <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.timeout_o <= 1'b0;
    end else begin
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= SETUP;
            owner       <= winner;
            bus.PSELx   <= 1'b1;
            bus.PENABLE <= 1'b0;
            bus.PWRITE  <= sel_write;
            bus.PADDR   <= sel_addr;
            bus.PWDATA  <= sel_wdata;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
          wait_cnt    <= CW'(TIMEOUT - 1);
        end
        ACCESS: begin
          if (bus.PREADY) begin
            bus.rsp_valid[owner] <= 1'b1;
            bus.rsp_rdata        <= bus.PWRITE ? '0 : bus.PRDATA;
            bus.rsp_err          <= bus.PSLVERR;
            bus.PENABLE          <= 1'b0;
            if (accept) begin
              state      <= SETUP;
              owner      <= winner;
              bus.PWRITE <= sel_write;
              bus.PADDR  <= sel_addr;
              bus.PWDATA <= sel_wdata;
            end else begin
              state     <= IDLE;
              bus.PSELx <= 1'b0;
            end
          end else if (wait_cnt == '0) begin
            // Terminal count reached with PREADY still low: abort.
            state                <= IDLE;
            bus.PSELx            <= 1'b0;
            bus.PENABLE          <= 1'b0;
            bus.rsp_valid[owner] <= 1'b1;
            bus.rsp_err          <= 1'b1;
            bus.timeout_o        <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          bus.PSELx   <= 1'b0;
          bus.PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: single write, wait-state read,
// round-robin back-to-back, slave error, timeout and mid-transfer reset.
module tb_apb_arb_master;

  logic PCLK;
  logic PRESETn;
  int   checks = 0;
  int   errors = 0;
  int   n;

  apb_arb_master_if #(.NREQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_arb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NREQ(2), .TIMEOUT(16)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_addr [8] = '{32'h100, 32'h100, 32'h200, 32'h200,
                                32'h100, 32'h100, 32'h200, 32'h200};
  logic        exp_pen  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0]  exp_rsp  [8] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn       = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_write = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;

    // reset values
    @(negedge PCLK); @(negedge PCLK);
    check_val("rst_ready",   bus.req_ready, 0);
    check_val("rst_psel",    bus.PSELx, 0);
    check_val("rst_penable", bus.PENABLE, 0);
    check_val("rst_pwrite",  bus.PWRITE, 0);
    check_val("rst_paddr",   bus.PADDR, 0);
    check_val("rst_pwdata",  bus.PWDATA, 0);
    check_val("rst_rspv",    bus.rsp_valid, 0);
    check_val("rst_tmo",     bus.timeout_o, 0);
    bus.req_valid = 2'b00;
    PRESETn       = 1'b1;
    @(negedge PCLK);

    // single write, zero wait states
    bus.req_valid = 2'b01;
    bus.req_write = 2'b01;
    bus.req_addr[31:0]  = 32'h10;
    bus.req_wdata[31:0] = 32'hDEADBEEF;
    #1 check_val("wr_ready", bus.req_ready, 2'b01);
    @(negedge PCLK);
    bus.req_valid = 2'b00;
    check_val("wr_setup_psel", bus.PSELx, 1);
    check_val("wr_setup_pen",  bus.PENABLE, 0);
    check_val("wr_paddr",      bus.PADDR, 32'h10);
    check_val("wr_pwrite",     bus.PWRITE, 1);
    check_val("wr_pwdata",     bus.PWDATA, 32'hDEADBEEF);
    @(negedge PCLK);
    check_val("wr_access_pen", bus.PENABLE, 1);
    check_val("wr_access_rsp", bus.rsp_valid, 0);
    @(negedge PCLK);
    check_val("wr_rspv",       bus.rsp_valid, 2'b01);
    check_val("wr_err",        bus.rsp_err, 0);
    check_val("wr_rdata",      bus.rsp_rdata, 0);
    check_val("wr_idle_psel",  bus.PSELx, 0);
    check_val("wr_hold_paddr", bus.PADDR, 32'h10);
    @(negedge PCLK);
    check_val("wr_rspv_pulse", bus.rsp_valid, 0);

    // read with three wait states; req0 raises and withdraws a command meanwhile
    bus.req_valid = 2'b10;
    bus.req_write = 2'b00;
    bus.req_addr[63:32] = 32'h20;
    bus.PREADY = 1'b0;
    #1 check_val("rd_ready", bus.req_ready, 2'b10);
    @(negedge PCLK);
    bus.req_valid = 2'b00;
    check_val("rd_setup_pen", bus.PENABLE, 0);
    check_val("rd_paddr",     bus.PADDR, 32'h20);
    check_val("rd_pwrite",    bus.PWRITE, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check_val("rd_access_sel", {bus.PSELx, bus.PENABLE}, 2'b11);
      check_val("rd_paddr_hold", bus.PADDR, 32'h20);
      if (i == 0) begin
        bus.req_valid = 2'b01;
        #1 check_val("rd_wait_noready", bus.req_ready, 2'b00);
      end
      if (i == 1) bus.req_valid = 2'b00;
      if (i == 3) begin
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h12345678;
      end
    end
    @(negedge PCLK);
    check_val("rd_rspv",  bus.rsp_valid, 2'b10);
    check_val("rd_rdata", bus.rsp_rdata, 32'h12345678);
    check_val("rd_err",   bus.rsp_err, 0);
    check_val("rd_idle",  bus.PSELx, 0);

    // round-robin with both requesters valid, back-to-back transfers
    bus.req_valid = 2'b11;
    bus.req_write = 2'b11;
    bus.req_addr  = {32'h200, 32'h100};
    bus.req_wdata = {32'hBBBB0001, 32'hAAAA0000};
    for (int c = 0; c < 8; c++) begin
      @(negedge PCLK);
      if (c == 6) bus.req_valid = 2'b00;
      check_val("rr_psel",    bus.PSELx, 1);
      check_val("rr_penable", bus.PENABLE, exp_pen[c]);
      check_val("rr_paddr",   bus.PADDR, exp_addr[c]);
      check_val("rr_rspv",    bus.rsp_valid, exp_rsp[c]);
    end
    @(negedge PCLK);
    check_val("rr_last_rspv", bus.rsp_valid, 2'b10);
    check_val("rr_idle",      bus.PSELx, 0);

    // slave error on a write, then a clean write
    bus.req_valid = 2'b01;
    bus.req_write = 2'b11;
    bus.req_addr  = {32'h34, 32'h30};
    bus.PSLVERR   = 1'b1;
    @(negedge PCLK);
    bus.req_valid = 2'b00;
    @(negedge PCLK);
    @(negedge PCLK);
    check_val("err_rspv", bus.rsp_valid, 2'b01);
    check_val("err_flag", bus.rsp_err, 1);
    bus.PSLVERR   = 1'b0;
    bus.req_valid = 2'b10;
    @(negedge PCLK);
    bus.req_valid = 2'b00;
    check_val("ok_paddr", bus.PADDR, 32'h34);
    @(negedge PCLK);
    @(negedge PCLK);
    check_val("ok_rspv", bus.rsp_valid, 2'b10);
    check_val("ok_err",  bus.rsp_err, 0);

    // timeout with PREADY held low
    bus.req_valid = 2'b01;
    bus.req_write = 2'b00;
    bus.req_addr[31:0] = 32'h40;
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hFFFFFFFF;
    @(negedge PCLK);
    bus.req_valid = 2'b00;
    check_val("tmo_setup_pen", bus.PENABLE, 0);
    @(negedge PCLK);
    n = 0;
    while (bus.PENABLE === 1'b1 && n < 40) begin
      n++;
      check_val("tmo_no_early", bus.timeout_o, 0);
      @(negedge PCLK);
    end
    check_val("tmo_access_cycles", n, 16);
    check_val("tmo_rspv",  bus.rsp_valid, 2'b01);
    check_val("tmo_err",   bus.rsp_err, 1);
    check_val("tmo_rdata", bus.rsp_rdata, 0);
    check_val("tmo_pulse", bus.timeout_o, 1);
    check_val("tmo_idle",  bus.PSELx, 0);
    @(negedge PCLK);
    check_val("tmo_pulse_end", bus.timeout_o, 0);
    check_val("tmo_rspv_end",  bus.rsp_valid, 0);
    bus.req_valid = 2'b01;
    #1 check_val("tmo_idle_ready", bus.req_ready, 2'b01);

    // reset in the middle of ACCESS (pointer is at 1 after this accept)
    bus.req_addr[31:0] = 32'h50;
    @(negedge PCLK);
    bus.req_valid = 2'b00;
    @(negedge PCLK);
    check_val("mid_access", {bus.PSELx, bus.PENABLE}, 2'b11);
    bus.req_valid = 2'b11;
    PRESETn = 1'b0;
    #1;
    check_val("mid_rst_psel",  bus.PSELx, 0);
    check_val("mid_rst_pen",   bus.PENABLE, 0);
    check_val("mid_rst_paddr", bus.PADDR, 0);
    check_val("mid_rst_ready", bus.req_ready, 0);
    @(negedge PCLK);
    bus.req_valid = 2'b00;
    bus.PREADY = 1'b1;
    PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check_val("post_rst_rspv", bus.rsp_valid, 0);
      check_val("post_rst_psel", bus.PSELx, 0);
    end
    bus.req_valid = 2'b11;
    #1 check_val("post_rst_ptr", bus.req_ready, 2'b01);
    @(negedge PCLK);
    bus.req_valid = 2'b00;
    @(negedge PCLK);
    @(negedge PCLK);
    @(negedge PCLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 Parameter DATA_WIDTH, default 32, APB data width.
REQ-003 Parameter NREQ, default 2, number of requesters (2..8).
REQ-004 Parameter TIMEOUT, default 16, max ACCESS cycles with PREADY low before abort.
REQ-005 PCLK  input  1  single clock; all state on rising edge.
REQ-006 PRESETn  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  NREQ  per-requester command valid.
REQ-008 req_ready  output  NREQ  per-requester command accept; one-hot or zero.
REQ-009 req_write  input  NREQ  1=write, 0=read.
REQ-010 req_addr  input  NREQ*ADDR_WIDTH  flattened addresses, requester i at slice i.
REQ-011 req_wdata  input  NREQ*DATA_WIDTH  flattened write data.
REQ-012 rsp_valid  output  NREQ  one-cycle completion pulse to owning requester.
REQ-013 rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid.
REQ-014 rsp_err  output  1  PSLVERR or timeout, valid with rsp_valid.
REQ-015 PSELx, PENABLE, PWRITE  output  1 each  APB control.
REQ-016 PADDR  output  ADDR_WIDTH; PWDATA  output  DATA_WIDTH  APB address/write data.
REQ-017 PRDATA  input  DATA_WIDTH; PREADY, PSLVERR  input  1 each  APB slave response.
REQ-018 timeout_o  output  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-019 FSM states IDLE, SETUP, ACCESS; reset state IDLE.
REQ-020 Arbitration round-robin over req_valid; search starts at pointer, pointer moves to winner+1 (mod NREQ) on each accept.
REQ-021 req_ready[winner] asserted combinationally in IDLE, and in ACCESS on the completing cycle; accept = req_valid & req_ready at a rising edge.
REQ-022 On accept: latch write/addr/wdata and owner index; next state SETUP.
REQ-023 SETUP: PSELx=1, PENABLE=0, exactly one cycle, then ACCESS.
REQ-024 ACCESS: PSELx=1, PENABLE=1; remain while PREADY=0 and wait count < TIMEOUT.
REQ-025 PADDR, PWRITE, PWDATA stable from SETUP through final ACCESS cycle; hold last value in IDLE.
REQ-026 Completion (PREADY=1 in ACCESS): next cycle rsp_valid[owner]=1 for one cycle; rsp_rdata=PRDATA if read, 0 if write; rsp_err=PSLVERR.
REQ-027 Completion with another accept in the same cycle: go directly to SETUP (PSELx stays 1, PENABLE drops to 0); otherwise IDLE.
REQ-028 Timeout: TIMEOUT consecutive ACCESS cycles with PREADY=0 -> leave ACCESS; next cycle rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0, timeout_o=1.
REQ-029 Minimum latency: accept at edge N, SETUP cycle N+1, ACCESS N+2, rsp_valid N+3 (zero wait states).
REQ-030 Requester dropping req_valid before accept is legal; no transfer issued.
REQ-031 PSELx, PENABLE, PADDR, PWRITE, PWDATA, rsp_* and timeout_o are registered outputs.

Reset
REQ-032 PRESETn low forces immediately: state IDLE, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout_o=0, pointer=0, wait count=0.
REQ-033 req_ready=0 while PRESETn low.
REQ-034 Reset mid-transfer drops the transfer; no rsp_valid issued for it after release.

Structure
REQ-035 Package apb_pkg holds ADDR_WIDTH/DATA_WIDTH defaults, TIMEOUT default, and enum apb_state_e {IDLE, SETUP, ACCESS}.
REQ-036 Sub-module apb_rr_arbiter: combinational winner from req vector and pointer, registered pointer update on accept.

Verification
REQ-037 Single write, req0 addr 0x10 data 0xDEADBEEF, PREADY tied 1 -> SETUP/ACCESS one cycle each, rsp_valid[0] at N+3, rsp_err=0.
REQ-038 Read req1 addr 0x20, PREADY low 3 ACCESS cycles, PRDATA=0x12345678 -> ACCESS lasts 4 cycles, PADDR stable, rsp_rdata=0x12345678 to requester 1.
REQ-039 req0 and req1 valid continuously, 4 transfers -> grants 0,1,0,1; back-to-back SETUP without IDLE between.
REQ-040 PREADY held 0 -> after 16 ACCESS cycles rsp_err=1, rsp_rdata=0, timeout_o pulse, FSM IDLE.
REQ-041 PSLVERR=1 with PREADY=1 on a write -> rsp_err=1 for that response only.
REQ-042 PRESETn low during ACCESS -> PSELx/PENABLE 0 same cycle, no rsp_valid after release, pointer 0.
